// File: rtl/forward_fifo.sv
// ---------------------------------------------------------------------------
// forward_fifo
//
// Ready/valid forward buffer with DEPTH entries of DATA_WIDTH bits. The head
// entry is driven straight from the storage registers, so there is never a
// combinational path from input_port_data to output_port_data. A full FIFO
// still accepts a write in the same cycle the consumer takes the head, which
// keeps one-word-per-cycle throughput at every fill level, including DEPTH=1.
// Also reports fill level, an almost-full flag and supports synchronous flush.
//
// Ports
//   clock_port         in   rising-edge clock
//   reset_port         in   asynchronous active-low reset
//   clear_port         in   synchronous flush; blocks both handshakes that cycle
//   input_port_data    in   write payload
//   input_port_valid   in   write request
//   input_port_ready   out  write accepted this cycle when valid is high
//   output_port_data   out  head-entry payload (registered)
//   output_port_valid  out  head entry present
//   output_port_ready  in   consumer takes the head this cycle
//   level_port         out  number of stored entries, 0..DEPTH
//   almost_full_port   out  level_port >= AFULL_LEVEL
// ---------------------------------------------------------------------------
module forward_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                       clock_port,
    input  logic                       reset_port,
    input  logic                       clear_port,
    input  logic [DATA_WIDTH-1:0]      input_port_data,
    input  logic                       input_port_valid,
    output logic                       input_port_ready,
    output logic [DATA_WIDTH-1:0]      output_port_data,
    output logic                       output_port_valid,
    input  logic                       output_port_ready,
    output logic [$clog2(DEPTH+1)-1:0] level_port,
    output logic                       almost_full_port
);

    // A single-entry FIFO still carries a 1-bit pointer that simply stays 0.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      count_q, count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Explicit wrap so non-power-of-two depths never rely on overflow.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    assign full  = (count_q == LVL_W'(DEPTH));
    assign empty = (count_q == '0);

    // When full, the slot freed by a concurrent pop is reused in the same cycle.
    assign input_port_ready  = ~clear_port & (~full | output_port_ready);
    assign output_port_valid = ~clear_port & ~empty;

    assign push = input_port_valid & input_port_ready;
    assign pop  = output_port_valid & output_port_ready;

    assign output_port_data = mem_q[rd_ptr_q];
    assign level_port       = count_q;
    // Signed int compare keeps AFULL_LEVEL=0 meaningful (always asserted).
    assign almost_full_port = (int'(count_q) >= AFULL_LEVEL);

    // Next-state for pointers and occupancy.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned; otherwise a latch would be inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (clear_port) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + LVL_W'(1);
                2'b01:   count_d = count_q - LVL_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock_port or negedge reset_port) begin
        if (!reset_port) begin
            // NOTE: non-blocking assignments for all sequential state, so every
            // register samples its inputs as they were before this edge.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage. Flush deliberately leaves contents alone; only pointers move.
    always_ff @(posedge clock_port or negedge reset_port) begin
        if (!reset_port) begin
            // NOTE: the array is reset so output_port_data reads 0 after
            // reset; this forces flops rather than a RAM macro, which is
            // acceptable for the small depths this buffer targets.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= input_port_data;
        end
    end

endmodule

// File: tb/tb_forward_fifo.sv
// ---------------------------------------------------------------------------
// tb_forward_fifo
//
// Three instances: DEPTH=4 (AFULL_LEVEL=3), DEPTH=3 (non-power-of-two wrap)
// and DEPTH=1 (single-entry behaviour). Stimulus pushes expected words into a
// per-instance queue as each write is issued; a monitor per instance pops and
// compares whenever the instance completes an output handshake.
// Inputs are driven 1 time unit after the rising edge; monitors sample on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_forward_fifo;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // DEPTH=4 instance
    logic       clr4, in_valid4, in_ready4, out_valid4, out_ready4, afull4;
    logic [7:0] in_data4, out_data4;
    logic [2:0] level4;
    // DEPTH=3 instance
    logic       clr3, in_valid3, in_ready3, out_valid3, out_ready3, afull3;
    logic [7:0] in_data3, out_data3;
    logic [1:0] level3;
    // DEPTH=1 instance
    logic       clr1, in_valid1, in_ready1, out_valid1, out_ready1, afull1;
    logic [7:0] in_data1, out_data1;
    logic [0:0] level1;

    logic [7:0] q4[$];
    logic [7:0] q3[$];
    logic [7:0] q1[$];

    forward_fifo #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_LEVEL(3)) dut4 (
        .clock_port(clk), .reset_port(rst_n), .clear_port(clr4),
        .input_port_data(in_data4), .input_port_valid(in_valid4),
        .input_port_ready(in_ready4), .output_port_data(out_data4),
        .output_port_valid(out_valid4), .output_port_ready(out_ready4),
        .level_port(level4), .almost_full_port(afull4)
    );

    forward_fifo #(.DATA_WIDTH(8), .DEPTH(3)) dut3 (
        .clock_port(clk), .reset_port(rst_n), .clear_port(clr3),
        .input_port_data(in_data3), .input_port_valid(in_valid3),
        .input_port_ready(in_ready3), .output_port_data(out_data3),
        .output_port_valid(out_valid3), .output_port_ready(out_ready3),
        .level_port(level3), .almost_full_port(afull3)
    );

    forward_fifo #(.DATA_WIDTH(8), .DEPTH(1)) dut1 (
        .clock_port(clk), .reset_port(rst_n), .clear_port(clr1),
        .input_port_data(in_data1), .input_port_valid(in_valid1),
        .input_port_ready(in_ready1), .output_port_data(out_data1),
        .output_port_valid(out_valid1), .output_port_ready(out_ready1),
        .level_port(level1), .almost_full_port(afull1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid4 && out_ready4) begin
            if (q4.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL d4 pop: got 0x%0h, want no transfer (nothing expected)", out_data4);
            end else begin
                check("d4 pop data", 32'(out_data4), 32'(q4.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid3 && out_ready3) begin
            if (q3.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL d3 pop: got 0x%0h, want no transfer (nothing expected)", out_data3);
            end else begin
                check("d3 pop data", 32'(out_data3), 32'(q3.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL d1 pop: got 0x%0h, want no transfer (nothing expected)", out_data1);
            end else begin
                check("d1 pop data", 32'(out_data1), 32'(q1.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    int         cnt3;
    int         cnt1;
    logic [7:0] seq3;
    logic [7:0] seq1;
    logic       exp_rdy;
    logic       exp_push;
    logic       exp_pop;

    initial begin
        rst_n = 1'b0;
        clr4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0; in_data4 = '0;
        clr3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0; in_data3 = '0;
        clr1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; in_data1 = '0;

        // Reset state, visible while reset is held.
        #2;
        check("rst d4 out_valid", 32'(out_valid4), 0);
        check("rst d4 out_data",  32'(out_data4),  0);
        check("rst d4 level",     32'(level4),     0);
        check("rst d4 in_ready",  32'(in_ready4),  1);
        check("rst d4 afull",     32'(afull4),     0);
        check("rst d3 afull",     32'(afull3),     0);
        check("rst d1 afull (AFULL_LEVEL=0)", 32'(afull1), 1);
        #20 rst_n = 1'b1;
        tick();
        check("idle d4 out_valid", 32'(out_valid4), 0);
        check("idle d4 level",     32'(level4),     0);
        check("idle d4 in_ready",  32'(in_ready4),  1);

        // Fill 0x11..0x44 with the consumer stalled.
        for (int i = 0; i < 4; i++) begin
            in_valid4 = 1'b1;
            in_data4  = 8'((i + 1) * 17);
            #1 check("fill d4 in_ready", 32'(in_ready4), 1);
            q4.push_back(in_data4);
            tick();
            check("fill d4 level", 32'(level4), 32'(i + 1));
            check("fill d4 afull", 32'(afull4), 32'(i + 1 >= 3));
        end
        in_data4 = 8'h55;
        #1;
        check("full d4 in_ready", 32'(in_ready4),  0);
        check("full d4 head",     32'(out_data4),  32'h11);
        check("full d4 valid",    32'(out_valid4), 1);
        in_valid4 = 1'b0;

        // Drain in consecutive cycles.
        out_ready4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain d4 valid", 32'(out_valid4), 1);
            check("drain d4 level", 32'(level4), 32'(4 - i));
            tick();
        end
        check("drained d4 level", 32'(level4),     0);
        check("drained d4 valid", 32'(out_valid4), 0);
        out_ready4 = 1'b0;

        // Full streaming: fill with 0xA0..0xA3, then 10 cycles push+pop.
        for (int i = 0; i < 4; i++) begin
            in_valid4 = 1'b1;
            in_data4  = 8'(8'hA0 + i);
            q4.push_back(in_data4);
            tick();
        end
        check("stream d4 start level", 32'(level4), 4);
        out_ready4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data4 = 8'(8'hB0 + i);
            #1 check("stream d4 in_ready", 32'(in_ready4), 1);
            q4.push_back(in_data4);
            tick();
            check("stream d4 level", 32'(level4), 4);
        end
        in_valid4 = 1'b0;
        repeat (4) tick();
        check("stream d4 end level", 32'(level4), 0);
        check("stream d4 all popped", 32'(q4.size()), 0);
        out_ready4 = 1'b0;

        // Flush at level 2 with a write pending.
        for (int i = 0; i < 2; i++) begin
            in_valid4 = 1'b1;
            in_data4  = 8'(8'hC1 + i);
            q4.push_back(in_data4);
            tick();
        end
        in_valid4 = 1'b0;
        check("pre-flush d4 level", 32'(level4), 2);
        clr4 = 1'b1; in_valid4 = 1'b1; in_data4 = 8'hEE; out_ready4 = 1'b1;
        #1;
        check("flush d4 in_ready",  32'(in_ready4),  0);
        check("flush d4 out_valid", 32'(out_valid4), 0);
        q4.delete();
        tick();
        clr4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0;
        check("post-flush d4 level", 32'(level4),     0);
        check("post-flush d4 valid", 32'(out_valid4), 0);
        in_valid4 = 1'b1; in_data4 = 8'hD7;
        #1 check("post-flush d4 in_ready", 32'(in_ready4), 1);
        q4.push_back(in_data4);
        tick();
        in_valid4 = 1'b0;
        check("post-flush d4 level1", 32'(level4),     1);
        check("post-flush d4 valid1", 32'(out_valid4), 1);
        check("post-flush d4 head",   32'(out_data4),  32'hD7);
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        check("post-flush d4 drained", 32'(level4), 0);

        // DEPTH=3: random valid/ready against a reference occupancy model.
        cnt3 = 0;
        seq3 = 8'h00;
        for (int c = 0; c < 1000; c++) begin
            in_valid3  = 1'($urandom_range(0, 1));
            out_ready3 = 1'($urandom_range(0, 1));
            in_data3   = seq3;
            exp_rdy  = (cnt3 != 3) || out_ready3;
            exp_push = in_valid3 && exp_rdy;
            exp_pop  = (cnt3 != 0) && out_ready3;
            #1 check("d3 in_ready", 32'(in_ready3), 32'(exp_rdy));
            if (exp_push) begin
                q3.push_back(seq3);
                seq3 = seq3 + 8'd1;
            end
            cnt3 = cnt3 + (exp_push ? 1 : 0) - (exp_pop ? 1 : 0);
            tick();
            check("d3 level", 32'(level3), 32'(cnt3));
        end
        in_valid3 = 1'b0; out_ready3 = 1'b1;
        repeat (4) tick();
        check("d3 drained level", 32'(level3), 0);
        check("d3 nothing lost", 32'(q3.size()), 0);
        out_ready3 = 1'b0;

        // DEPTH=1: alternating stalls, then consumer always ready.
        cnt1 = 0;
        seq1 = 8'h60;
        for (int c = 0; c < 20; c++) begin
            in_valid1  = 1'b1;
            out_ready1 = (c < 12) ? ~c[0] : 1'b1;
            in_data1   = seq1;
            exp_rdy  = (cnt1 == 0) || out_ready1;
            exp_push = in_valid1 && exp_rdy;
            exp_pop  = (cnt1 == 1) && out_ready1;
            #1;
            check("d1 in_ready",  32'(in_ready1),  32'(exp_rdy));
            check("d1 out_valid", 32'(out_valid1), 32'(cnt1 == 1));
            if (exp_push) begin
                q1.push_back(seq1);
                seq1 = seq1 + 8'd1;
            end
            cnt1 = cnt1 + (exp_push ? 1 : 0) - (exp_pop ? 1 : 0);
            tick();
            check("d1 level", 32'(level1), 32'(cnt1));
        end
        in_valid1 = 1'b0; out_ready1 = 1'b1;
        tick();
        check("d1 drained level", 32'(level1), 0);
        check("d1 nothing lost", 32'(q1.size()), 0);
        out_ready1 = 1'b0;

        // Reset mid-operation drops stored entries immediately.
        for (int i = 0; i < 2; i++) begin
            in_valid4 = 1'b1;
            in_data4  = 8'(8'hF1 + i);
            tick();
        end
        in_valid4 = 1'b0;
        check("pre-reset d4 level", 32'(level4), 2);
        #1 rst_n = 1'b0;
        #1;
        check("mid-reset d4 level",     32'(level4),     0);
        check("mid-reset d4 out_valid", 32'(out_valid4), 0);
        check("mid-reset d4 out_data",  32'(out_data4),  0);
        check("mid-reset d4 in_ready",  32'(in_ready4),  1);
        #1 rst_n = 1'b1;
        tick();
        check("post-reset d4 level", 32'(level4),     0);
        check("post-reset d4 valid", 32'(out_valid4), 0);

        check("d4 scoreboard empty", 32'(q4.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/forward_fifo.md
# forward_fifo

- Parametrised ready/valid forward buffer: a DEPTH-entry, DATA_WIDTH-bit FIFO with registered output.
- With DEPTH=1 it behaves cycle-for-cycle like the team's single-entry forward buffer.
- Adds fill level, an almost-full flag and a synchronous flush.
- Sits between pipeline stages and on bus-side queues where more than one entry of elasticity is needed without losing full throughput.

## Interface
- DATA_WIDTH, 8, payload width in bits (>=1)
- DEPTH, 4, number of storage entries (>=1, need not be a power of two)
- AFULL_LEVEL, DEPTH-1, fill level at or above which almost_full_port asserts (0..DEPTH)
- clock_port  in  1  single clock; all state updates on rising edge
- reset_port  in  1  asynchronous, active-low reset
- clear_port  in  1  synchronous flush, active-high
- input_port_data  in  DATA_WIDTH  write payload
- input_port_valid  in  1  write request
- input_port_ready  out  1  FIFO accepts write this cycle
- output_port_data  out  DATA_WIDTH  head-entry payload
- output_port_valid  out  1  head entry present
- output_port_ready  in  1  consumer accepts head this cycle
- level_port  out  $clog2(DEPTH+1)  current number of stored entries
- almost_full_port  out  1  level_port >= AFULL_LEVEL

## Operation
- **State**
  - DEPTH x DATA_WIDTH storage array.
  - Write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits (1 bit when DEPTH=1).
  - Counter count, 0..DEPTH.
- **Handshake signals**
  - push = input_port_valid & input_port_ready
  - pop = output_port_valid & output_port_ready
- **Ready/valid**
  - input_port_ready = ~clear_port & ((count != DEPTH) | output_port_ready). When full, a write is accepted in the same cycle as a read.
  - output_port_valid = ~clear_port & (count != 0).
- **Data path**
  - output_port_data = storage[rd_ptr], taken from registers only.
  - There is no combinational path from input_port_data to output_port_data.
- **On push:** storage[wr_ptr] <= input_port_data, and wr_ptr advances.
- **On pop:** rd_ptr advances.
- **Pointer wrap:** pointer == DEPTH-1 wraps to 0. Non-power-of-two depths wrap explicitly, never by overflow.
- **count update**
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.
- **level_port and almost_full_port:** level_port = count. almost_full_port is decoded combinationally from count.
- **Flush:** clear_port high resets count, wr_ptr and rd_ptr to 0 at the next edge and suppresses both handshakes that cycle. Storage contents are not cleared.
- **Reset (reset_port low, immediate):**
  - count, wr_ptr and rd_ptr are 0, and storage entries are all 0.
  - Hence output_port_valid=0, output_port_data=0, level_port=0, input_port_ready=1 (when clear_port=0).
  - almost_full_port = (AFULL_LEVEL==0).
- **Reset mid-operation:** all stored entries are dropped. No partial transfer is visible after release.

## Timing
- **Latency:** a word pushed at edge N is presented on output_port_data/valid after edge N, so at the earliest it can be popped in the cycle following the push.
- **Throughput:** one push and one pop per cycle sustained at any count, including full (DEPTH) and DEPTH=1.
- **Combinational paths**
  - input_port_ready depends combinationally on output_port_ready and clear_port.
  - output_port_valid depends on clear_port only, besides state.
  - No other input-to-output combinational paths exist.
- **Empty plus simultaneous valid:** no pop occurs that cycle (output_port_valid=0); the push is stored.
- **Full with output_port_ready=0:** input_port_ready=0 and data is held stable.
- **Stability under stall:** output_port_data and output_port_valid hold while output_port_valid=1 and output_port_ready=0, absent clear or reset.
- **Ordering:** strict FIFO order, including across pointer wrap.

## Test plan
- **Reset/idle:** hold reset_port low, then release → output_port_valid=0, output_port_data=0, level_port=0, input_port_ready=1, almost_full_port=0 (DEPTH=4, AFULL_LEVEL=3).
- **Fill/drain:** DEPTH=4, output_port_ready=0, push 0x11,0x22,0x33,0x44 → level_port 1,2,3,4 and almost_full_port asserts at level 3. Input_port_ready=0 at 4. Then drain with ready=1 → outputs 0x11..0x44 in consecutive cycles.
- **Full streaming:** FIFO full, input_port_valid=output_port_ready=1 for 10 cycles with incrementing data → one word in and one out per cycle, level_port stays 4, order preserved.
- **Wrap, non-power-of-two:** DEPTH=3, random valid/ready for 1000 cycles against a scoreboard → no loss, duplication or reorder; level_port always matches the model.
- **Flush:** level 2, assert clear_port for one cycle with input_port_valid=1 → no push, no pop that cycle, level_port=0 after the edge, and the next push appears as head.
- **DEPTH=1 equivalence:** single-entry configuration under alternating stalls → the entry is occupied the cycle after each accepted write. When full, input_port_ready equals output_port_ready, and back-to-back transfers occur when the consumer is always ready.
